spi_master_o: RTL and testbench

Write-only SPI master that serialises one DATA_WIDTH-bit word per request to a DAC-style slave.
- Framing: sync_o is an active-low frame select; data goes out MSB first on sdi_o with serial clock sclk_o.
- Guard time: after each frame, sync_o is held high for WAIT_CYCLES clocks before the next request is accepted.
- Placement: sits in the measure unit between a register/control interface (data_i, wre_i, rdy) and the DAC pins.

---
 rtl/spi_master_pkg.sv | 20 ++
 rtl/spi_master_o.sv | 154 +++++++++++++++
 tb/tb_spi_master_o.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and helpers for the write-only SPI master.
// Provides the FSM state encoding and the counter-width helper.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/spi_master_o.sv
// Write-only SPI master: one DATA_WIDTH-bit word per request, MSB first, sclk = clk/2.
// sync_o frames the word and stays high for WAIT_CYCLES clocks before the next accept.
module spi_master_o
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 5
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  wre_i,
    output logic                  rdy,
    output logic                  sdi_o,
    output logic                  sclk_o,
    output logic                  sync_o
);

    localparam int   BCW      = cnt_width(DATA_WIDTH);
    localparam int   WCW      = cnt_width(WAIT_CYCLES);
    localparam logic FAST_RDY = (WAIT_CYCLES == 0);

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   shreg_r, shreg_s;
    logic [BCW-1:0]          bit_cnt_r, bit_cnt_s;
    logic                    phase_r, phase_s;
    logic [WCW-1:0]          wait_cnt_r, wait_cnt_s;
    logic                    rdy_s, sdi_s, sclk_s, sync_s;

    // State, datapath and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            bit_cnt_r  <= '0;
            phase_r    <= 1'b0;
            wait_cnt_r <= '0;
            rdy        <= 1'b1;
            sdi_o      <= 1'b0;
            sclk_o     <= 1'b1;
            sync_o     <= 1'b1;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            bit_cnt_r  <= bit_cnt_s;
            phase_r    <= phase_s;
            wait_cnt_r <= wait_cnt_s;
            rdy        <= rdy_s;
            sdi_o      <= sdi_s;
            sclk_o     <= sclk_s;
            sync_o     <= sync_s;
        end
    end

    // Next-state and counter logic; phase is the clk/2 divider for sclk.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        bit_cnt_s  = bit_cnt_r;
        phase_s    = phase_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            IDLE: begin
                if (wre_i) begin
                    state_s   = SHIFT;
                    shreg_s   = data_i;
                    bit_cnt_s = BCW'(DATA_WIDTH - 1);
                    phase_s   = 1'b0;
                end else begin
                    state_s   = IDLE;
                end
            end
            SHIFT: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else if (bit_cnt_r != '0) begin
                    bit_cnt_s = bit_cnt_r - BCW'(1);
                    phase_s   = 1'b0;
                end else begin
                    phase_s = 1'b0;
                    if (WAIT_CYCLES > 0) begin
                        wait_cnt_s = WCW'(WAIT_CYCLES - 1);
                        state_s    = WAIT;
                    end else begin
                        state_s    = IDLE;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_r == '0) begin
                    state_s = IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r - WCW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next values of the registered pins; sdi only moves with sclk rising or at frame start.
    always_comb begin
        rdy_s  = rdy;
        sdi_s  = sdi_o;
        sclk_s = sclk_o;
        sync_s = sync_o;
        case (state_r)
            IDLE: begin
                sclk_s = 1'b1;
                if (wre_i) begin
                    rdy_s  = 1'b0;
                    sync_s = 1'b0;
                    sdi_s  = data_i[DATA_WIDTH-1];
                end else begin
                    rdy_s  = 1'b1;
                    sync_s = 1'b1;
                    sdi_s  = 1'b0;
                end
            end
            SHIFT: begin
                if (!phase_r) begin
                    sclk_s = 1'b0;
                end else begin
                    sclk_s = 1'b1;
                    if (bit_cnt_r != '0) begin
                        sdi_s = shreg_r[bit_cnt_r - BCW'(1)];
                    end else begin
                        sync_s = 1'b1;
                        sdi_s  = 1'b0;
                        rdy_s  = FAST_RDY;
                    end
                end
            end
            WAIT: begin
                sync_s = 1'b1;
                sclk_s = 1'b1;
                sdi_s  = 1'b0;
                if (wait_cnt_r == '0) begin
                    rdy_s = 1'b1;
                end else begin
                    rdy_s = 1'b0;
                end
            end
            default: begin
                rdy_s  = 1'b1;
                sync_s = 1'b1;
                sclk_s = 1'b1;
                sdi_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_o.sv
// Directed bench for spi_master_o: default 8-bit/5-wait instance and a 12-bit/0-wait instance.
// Outputs are sampled on the falling clk edge and compared per clock against hand-derived frames.
module tb_spi_master_o;

    logic        clk = 1'b0;
    logic        arst;
    logic [7:0]  data_a;
    logic        wre_a;
    logic        rdy_a, sdi_a, sclk_a, sync_a;
    logic [11:0] data_b;
    logic        wre_b;
    logic        rdy_b, sdi_b, sclk_b, sync_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master_o #(.DATA_WIDTH(8), .WAIT_CYCLES(5)) dut_a (
        .clk_i(clk), .arst_i(arst), .data_i(data_a), .wre_i(wre_a),
        .rdy(rdy_a), .sdi_o(sdi_a), .sclk_o(sclk_a), .sync_o(sync_a)
    );

    spi_master_o #(.DATA_WIDTH(12), .WAIT_CYCLES(0)) dut_b (
        .clk_i(clk), .arst_i(arst), .data_i(data_b), .wre_i(wre_b),
        .rdy(rdy_b), .sdi_o(sdi_b), .sclk_o(sclk_b), .sync_o(sync_b)
    );

    task automatic check(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Packed as {rdy, sdi, sclk, sync}.
    function automatic logic [3:0] obs_pins(input bit sel);
        if (sel) return {rdy_b, sdi_b, sclk_b, sync_b};
        else     return {rdy_a, sdi_a, sclk_a, sync_a};
    endfunction

    // Expected pins k edges after the accepting edge.
    function automatic logic [3:0] expect_at(input int k, input int dw, input int w, input logic [15:0] word);
        if (k < 2 * dw) begin
            return {1'b0, word[dw - 1 - k / 2], ((k % 2) == 0) ? 1'b1 : 1'b0, 1'b0};
        end else if (k < 2 * dw + w) begin
            return 4'b0011;
        end else begin
            return 4'b1011;
        end
    endfunction

    // Caller raises wre at a negedge while idle; the next posedge is the accepting edge.
    task automatic run_frame(input string tag, input bit sel, input logic [15:0] word,
                             input bit keep, input bit pulse);
        int   dw;
        int   w;
        int   falls;
        logic prev_sclk;
        logic [3:0] p;
        dw        = sel ? 12 : 8;
        w         = sel ? 0 : 5;
        falls     = 0;
        prev_sclk = 1'b1;
        for (int k = 0; k <= 2 * dw + w; k++) begin
            @(negedge clk);
            p = obs_pins(sel);
            check(tag, k, {12'h000, p}, {12'h000, expect_at(k, dw, w, word)});
            if (prev_sclk && !p[1] && !p[0]) falls++;
            prev_sclk = p[1];
            if (k == 0 && !keep) begin
                if (sel) begin
                    wre_b  = 1'b0;
                    data_b = ~data_b;
                end else begin
                    wre_a  = 1'b0;
                    data_a = ~data_a;
                end
            end
            if (pulse && k == 5) begin
                wre_a  = 1'b1;
                data_a = 8'h55;
            end
            if (pulse && k == 6) wre_a = 1'b0;
        end
        check({tag, "_falls"}, 0, 16'(falls), 16'(dw));
    endtask

    initial begin
        arst   = 1'b1;
        wre_a  = 1'b0;
        wre_b  = 1'b0;
        data_a = 8'h00;
        data_b = 12'h000;
        @(negedge clk);
        @(negedge clk);
        check("reset_a", 0, {12'h000, obs_pins(1'b0)}, 16'h000B);
        check("reset_b", 0, {12'h000, obs_pins(1'b1)}, 16'h000B);
        arst = 1'b0;
        @(negedge clk);
        check("idle_a", 0, {12'h000, obs_pins(1'b0)}, 16'h000B);

        data_a = 8'hAA; wre_a = 1'b1;
        run_frame("aa", 1'b0, 16'h00AA, 1'b0, 1'b0);
        data_a = 8'hFF; wre_a = 1'b1;
        run_frame("ff", 1'b0, 16'h00FF, 1'b0, 1'b0);
        data_a = 8'h00; wre_a = 1'b1;
        run_frame("zero", 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_sdi", 0, {12'h000, obs_pins(1'b0)}, 16'h000B);

        data_a = 8'hAA; wre_a = 1'b1;
        run_frame("ignore55", 1'b0, 16'h00AA, 1'b0, 1'b1);

        data_a = 8'h81; wre_a = 1'b1;
        run_frame("hold1", 1'b0, 16'h0081, 1'b1, 1'b0);
        run_frame("hold2", 1'b0, 16'h0081, 1'b1, 1'b0);
        run_frame("hold3", 1'b0, 16'h0081, 1'b0, 1'b0);

        data_a = 8'hAA; wre_a = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            check("pre_abort", k, {12'h000, obs_pins(1'b0)}, {12'h000, expect_at(k, 8, 5, 16'h00AA)});
            if (k == 0) wre_a = 1'b0;
        end
        arst = 1'b1;
        @(negedge clk);
        check("abort", 7, {12'h000, obs_pins(1'b0)}, 16'h000B);
        arst = 1'b0;
        data_a = 8'hC3; wre_a = 1'b1;
        run_frame("post_abort", 1'b0, 16'h00C3, 1'b0, 1'b0);

        data_b = 12'hA5C; wre_b = 1'b1;
        run_frame("w0_a5c", 1'b1, 16'h0A5C, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_b", 0, {12'h000, obs_pins(1'b1)}, 16'h000B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
